// File: rtl/tod_ctrl.sv
// Request sequencer for tod_core: fixed-priority init > step > slew arbitration into set pulses and per-cycle increment.
// Latency: pulse/data 1 cycle after accept, 3-cycle minimum init/step spacing; backpressure: ready low outside IDLE, slew also while a slew runs.
module tod_ctrl #(
    parameter int TIME_WIDTH_SUB_NS = 7,
    parameter int TIME_WIDTH_NS     = 32,
    parameter int TIME_WIDTH_SEC    = 32,
    parameter int SLEW_CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TIME_WIDTH_SUB_NS-1:0] nom_incr_sub_ns,
    input  logic [TIME_WIDTH_NS-1:0]     nom_incr_ns,
    input  logic                         init_req_valid,
    output logic                         init_req_ready,
    input  logic [TIME_WIDTH_SUB_NS-1:0] init_req_sub_ns,
    input  logic [TIME_WIDTH_NS-1:0]     init_req_ns,
    input  logic [TIME_WIDTH_SEC-1:0]    init_req_sec,
    input  logic                         step_req_valid,
    output logic                         step_req_ready,
    input  logic                         step_req_plus,
    input  logic [TIME_WIDTH_SUB_NS-1:0] step_req_sub_ns,
    input  logic [TIME_WIDTH_NS-1:0]     step_req_ns,
    input  logic                         slew_req_valid,
    output logic                         slew_req_ready,
    input  logic                         slew_req_plus,
    input  logic [TIME_WIDTH_SUB_NS-1:0] slew_req_delta_sub_ns,
    input  logic [TIME_WIDTH_NS-1:0]     slew_req_delta_ns,
    input  logic [SLEW_CNT_WIDTH-1:0]    slew_req_cycles,
    output logic                         set_init_time,
    output logic                         set_offset_time,
    output logic                         plus_offset_time,
    output logic [TIME_WIDTH_SUB_NS-1:0] init_time_sub_ns,
    output logic [TIME_WIDTH_NS-1:0]     init_time_ns,
    output logic [TIME_WIDTH_SEC-1:0]    init_time_sec,
    output logic [TIME_WIDTH_SUB_NS-1:0] offset_time_sub_ns,
    output logic [TIME_WIDTH_NS-1:0]     offset_time_ns,
    output logic [TIME_WIDTH_SUB_NS-1:0] incr_time_sub_ns,
    output logic [TIME_WIDTH_NS-1:0]     incr_time_ns,
    output logic                         slew_active,
    output logic                         slew_done,
    output logic                         busy
);
    localparam int IW = TIME_WIDTH_NS + TIME_WIDTH_SUB_NS;

    typedef enum logic [1:0] {IDLE, INIT_PULSE, STEP_PULSE, GUARD} state_t;

    typedef struct packed {
        logic          plus;
        logic [IW-1:0] delta;
    } slew_cfg_t;

    state_t                    state;
    slew_cfg_t                 slew_cfg;
    logic [SLEW_CNT_WIDTH-1:0] slew_cnt;
    logic                      slew_run;
    logic                      slew_active_nxt;
    logic                      idle;
    logic                      init_acc;
    logic                      step_acc;
    logic                      slew_acc;
    logic [IW-1:0]             nom_incr;
    logic [IW:0]               plus_sum;
    logic [IW-1:0]             plus_sat;
    logic [IW-1:0]             minus_sat;
    logic [IW-1:0]             incr_nxt;

    assign idle           = (state == IDLE);
    assign init_req_ready = idle;
    assign step_req_ready = idle && !init_req_valid;
    assign slew_req_ready = idle && !slew_active && !init_req_valid && !step_req_valid;

    assign init_acc = init_req_valid && init_req_ready;
    assign step_acc = step_req_valid && step_req_ready;
    assign slew_acc = slew_req_valid && slew_req_ready;

    assign busy = !idle || slew_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            set_init_time      <= 1'b0;
            set_offset_time    <= 1'b0;
            plus_offset_time   <= 1'b0;
            init_time_sub_ns   <= '0;
            init_time_ns       <= '0;
            init_time_sec      <= '0;
            offset_time_sub_ns <= '0;
            offset_time_ns     <= '0;
        end else begin
            set_init_time   <= 1'b0;
            set_offset_time <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_acc) begin
                        state            <= INIT_PULSE;
                        set_init_time    <= 1'b1;
                        init_time_sub_ns <= init_req_sub_ns;
                        init_time_ns     <= init_req_ns;
                        init_time_sec    <= init_req_sec;
                    end else if (step_acc) begin
                        state              <= STEP_PULSE;
                        set_offset_time    <= 1'b1;
                        plus_offset_time   <= step_req_plus;
                        offset_time_sub_ns <= step_req_sub_ns;
                        offset_time_ns     <= step_req_ns;
                    end
                end
                INIT_PULSE, STEP_PULSE: state <= GUARD;
                default:                state <= IDLE;
            endcase
        end
    end

    // The adjusted increment tracks the live nominal value so a nominal change mid-slew still lands one cycle later.
    always_comb begin
        nom_incr        = {nom_incr_ns, nom_incr_sub_ns};
        plus_sum        = {1'b0, nom_incr} + {1'b0, slew_cfg.delta};
        plus_sat        = plus_sum[IW] ? {IW{1'b1}} : plus_sum[IW-1:0];
        minus_sat       = (nom_incr >= slew_cfg.delta) ? (nom_incr - slew_cfg.delta) : '0;
        slew_active_nxt = 1'b0;
        if (!init_acc && !slew_acc && slew_run) begin
            slew_active_nxt = (slew_cnt != '0);
        end
        incr_nxt = nom_incr;
        if (slew_active_nxt) begin
            incr_nxt = slew_cfg.plus ? plus_sat : minus_sat;
        end
    end

    // slew_run spans the accept-to-done window; the cycle with a zero count ends it and raises slew_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slew_cnt         <= '0;
            slew_run         <= 1'b0;
            slew_cfg         <= '0;
            slew_active      <= 1'b0;
            slew_done        <= 1'b0;
            incr_time_ns     <= '0;
            incr_time_sub_ns <= '0;
        end else begin
            slew_done                        <= 1'b0;
            slew_active                      <= slew_active_nxt;
            {incr_time_ns, incr_time_sub_ns} <= incr_nxt;
            if (init_acc) begin
                slew_cnt <= '0;
                slew_run <= 1'b0;
            end else if (slew_acc) begin
                slew_cnt       <= slew_req_cycles;
                slew_run       <= 1'b1;
                slew_cfg.plus  <= slew_req_plus;
                slew_cfg.delta <= {slew_req_delta_ns, slew_req_delta_sub_ns};
            end else if (slew_run) begin
                if (slew_cnt != '0) begin
                    slew_cnt <= slew_cnt - SLEW_CNT_WIDTH'(1);
                end else begin
                    slew_run  <= 1'b0;
                    slew_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tod_ctrl.sv
// Directed bench for tod_ctrl: a timestamp-based model of accepts, pulses and slew windows is compared every cycle,
// plus literal expectations at the points the test plan names.
module tb_tod_ctrl;
    localparam int SUB = 7;
    localparam int NS  = 32;
    localparam int SEC = 32;
    localparam int CW  = 16;
    localparam logic [63:0] MAXV = (64'd1 << (NS + SUB)) - 64'd1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [SUB-1:0] nom_incr_sub_ns;
    logic [NS-1:0]  nom_incr_ns;
    logic           init_req_valid, init_req_ready;
    logic [SUB-1:0] init_req_sub_ns;
    logic [NS-1:0]  init_req_ns;
    logic [SEC-1:0] init_req_sec;
    logic           step_req_valid, step_req_ready, step_req_plus;
    logic [SUB-1:0] step_req_sub_ns;
    logic [NS-1:0]  step_req_ns;
    logic           slew_req_valid, slew_req_ready, slew_req_plus;
    logic [SUB-1:0] slew_req_delta_sub_ns;
    logic [NS-1:0]  slew_req_delta_ns;
    logic [CW-1:0]  slew_req_cycles;
    logic           set_init_time, set_offset_time, plus_offset_time;
    logic [SUB-1:0] init_time_sub_ns, offset_time_sub_ns, incr_time_sub_ns;
    logic [NS-1:0]  init_time_ns, offset_time_ns, incr_time_ns;
    logic [SEC-1:0] init_time_sec;
    logic           slew_active, slew_done, busy;

    always #5 clk = ~clk;

    tod_ctrl #(
        .TIME_WIDTH_SUB_NS(SUB), .TIME_WIDTH_NS(NS), .TIME_WIDTH_SEC(SEC), .SLEW_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .nom_incr_sub_ns(nom_incr_sub_ns), .nom_incr_ns(nom_incr_ns),
        .init_req_valid(init_req_valid), .init_req_ready(init_req_ready),
        .init_req_sub_ns(init_req_sub_ns), .init_req_ns(init_req_ns), .init_req_sec(init_req_sec),
        .step_req_valid(step_req_valid), .step_req_ready(step_req_ready), .step_req_plus(step_req_plus),
        .step_req_sub_ns(step_req_sub_ns), .step_req_ns(step_req_ns),
        .slew_req_valid(slew_req_valid), .slew_req_ready(slew_req_ready), .slew_req_plus(slew_req_plus),
        .slew_req_delta_sub_ns(slew_req_delta_sub_ns), .slew_req_delta_ns(slew_req_delta_ns),
        .slew_req_cycles(slew_req_cycles),
        .set_init_time(set_init_time), .set_offset_time(set_offset_time), .plus_offset_time(plus_offset_time),
        .init_time_sub_ns(init_time_sub_ns), .init_time_ns(init_time_ns), .init_time_sec(init_time_sec),
        .offset_time_sub_ns(offset_time_sub_ns), .offset_time_ns(offset_time_ns),
        .incr_time_sub_ns(incr_time_sub_ns), .incr_time_ns(incr_time_ns),
        .slew_active(slew_active), .slew_done(slew_done), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycle k is the interval after the k-th clock edge since reset release.
    int          e, idle_from, s_lo, s_hi, done_cyc, ip_cyc, sp_cyc;
    logic [63:0] m_nom, m_delta;
    logic        m_splus, m_oplus;
    logic [63:0] m_init_sub, m_init_ns, m_init_sec, m_off_sub, m_off_ns;
    bit          m_idl, m_ia, m_sa, m_la;

    function automatic bit m_idle(int k);
        return k >= idle_from;
    endfunction

    function automatic bit m_act(int k);
        return (k >= s_lo) && (k <= s_hi);
    endfunction

    function automatic logic [63:0] m_incr(int k);
        if (k == 0) return 64'd0;
        if (!m_act(k)) return m_nom;
        if (m_splus) return (m_nom + m_delta > MAXV) ? MAXV : m_nom + m_delta;
        return (m_nom >= m_delta) ? m_nom - m_delta : 64'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; idle_from = 0; s_lo = 1; s_hi = 0; done_cyc = -1; ip_cyc = -1; sp_cyc = -1;
            m_nom = 0; m_delta = 0; m_splus = 0; m_oplus = 0;
            m_init_sub = 0; m_init_ns = 0; m_init_sec = 0; m_off_sub = 0; m_off_ns = 0;
        end else begin
            m_idl = m_idle(e);
            m_ia  = m_idl && init_req_valid;
            m_sa  = m_idl && !init_req_valid && step_req_valid;
            m_la  = m_idl && !init_req_valid && !step_req_valid && !m_act(e) && slew_req_valid;
            e++;
            if (m_ia) begin
                idle_from = e + 2; ip_cyc = e;
                m_init_sub = 64'(init_req_sub_ns); m_init_ns = 64'(init_req_ns); m_init_sec = 64'(init_req_sec);
                if (s_hi >= e) s_hi = e - 1;
                if (done_cyc >= e) done_cyc = -1;
            end
            if (m_sa) begin
                idle_from = e + 2; sp_cyc = e;
                m_oplus = step_req_plus; m_off_sub = 64'(step_req_sub_ns); m_off_ns = 64'(step_req_ns);
            end
            if (m_la) begin
                s_lo = e + 1; s_hi = e + int'(slew_req_cycles); done_cyc = s_hi + 1;
                m_splus = slew_req_plus;
                m_delta = 64'({slew_req_delta_ns, slew_req_delta_sub_ns});
            end
            m_nom = 64'({nom_incr_ns, nom_incr_sub_ns});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst set_init_time", 64'(set_init_time), 64'd0);
            chk("rst set_offset_time", 64'(set_offset_time), 64'd0);
            chk("rst incr_time", 64'({incr_time_ns, incr_time_sub_ns}), 64'd0);
            chk("rst slew_active", 64'(slew_active), 64'd0);
            chk("rst slew_done", 64'(slew_done), 64'd0);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst init_time_sec", 64'(init_time_sec), 64'd0);
        end else begin
            chk("set_init_time", 64'(set_init_time), 64'(e == ip_cyc));
            chk("set_offset_time", 64'(set_offset_time), 64'(e == sp_cyc));
            chk("init_time_sub_ns", 64'(init_time_sub_ns), m_init_sub);
            chk("init_time_ns", 64'(init_time_ns), m_init_ns);
            chk("init_time_sec", 64'(init_time_sec), m_init_sec);
            chk("plus_offset_time", 64'(plus_offset_time), 64'(m_oplus));
            chk("offset_time_sub_ns", 64'(offset_time_sub_ns), m_off_sub);
            chk("offset_time_ns", 64'(offset_time_ns), m_off_ns);
            chk("incr_time", 64'({incr_time_ns, incr_time_sub_ns}), m_incr(e));
            chk("slew_active", 64'(slew_active), 64'(m_act(e)));
            chk("slew_done", 64'(slew_done), 64'(e == done_cyc));
            chk("busy", 64'(busy), 64'(!m_idle(e) || m_act(e)));
            chk("init_req_ready", 64'(init_req_ready), 64'(m_idle(e)));
            chk("step_req_ready", 64'(step_req_ready), 64'(m_idle(e) && !init_req_valid));
            chk("slew_req_ready", 64'(slew_req_ready),
                64'(m_idle(e) && !m_act(e) && !init_req_valid && !step_req_valid));
        end
    end

    int cyc_cnt = 0;
    int last_init_cyc = -100;
    int last_step_cyc = -100;
    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) begin
        if (set_init_time) last_init_cyc = cyc_cnt;
        if (set_offset_time) last_step_cyc = cyc_cnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a slew request at the next edge, then counts active/done over n cycles,
    // checking the increment against a literal during every active cycle.
    task automatic run_slew(input bit plus, input logic [NS-1:0] dns, input logic [SUB-1:0] dsub,
                            input int cycles, input int n, input logic [63:0] lit_incr,
                            output int act_cnt, output int done_cnt);
        slew_req_valid = 1'b1; slew_req_plus = plus;
        slew_req_delta_ns = dns; slew_req_delta_sub_ns = dsub; slew_req_cycles = CW'(cycles);
        tick();
        slew_req_valid = 1'b0;
        act_cnt = 0; done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (slew_active) begin
                act_cnt++;
                chk("slew literal incr", 64'({incr_time_ns, incr_time_sub_ns}), lit_incr);
            end
            if (slew_done) done_cnt++;
        end
    endtask

    int ac, dc;

    initial begin
        nom_incr_ns = 32'd5; nom_incr_sub_ns = '0;
        init_req_valid = 0; init_req_sub_ns = '0; init_req_ns = '0; init_req_sec = '0;
        step_req_valid = 0; step_req_plus = 0; step_req_sub_ns = '0; step_req_ns = '0;
        slew_req_valid = 0; slew_req_plus = 0; slew_req_delta_sub_ns = '0; slew_req_delta_ns = '0;
        slew_req_cycles = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("incr before first edge", 64'(incr_time_ns), 64'd0);
        tick();
        chk("incr nominal after release", 64'(incr_time_ns), 64'd5);
        chk("no pulse after release", 64'({set_init_time, set_offset_time}), 64'd0);

        // init and step together: init wins, step follows after GUARD
        init_req_valid = 1; init_req_sec = 32'h1234_5678; init_req_ns = 32'h3B9A_C9FF; init_req_sub_ns = 7'h55;
        step_req_valid = 1; step_req_plus = 1; step_req_ns = 32'd100; step_req_sub_ns = 7'h03;
        tick();
        init_req_valid = 0;
        repeat (3) tick();
        step_req_valid = 0;
        repeat (3) tick();
        chk("set_offset 3 cycles after set_init", 64'(last_step_cyc - last_init_cyc), 64'd3);
        chk("init_time_sec literal", 64'(init_time_sec), 64'h1234_5678);
        chk("offset_time_ns literal", 64'(offset_time_ns), 64'd100);

        run_slew(1'b1, 32'd1, 7'd0, 4, 8, 64'(6) << SUB, ac, dc);
        chk("slew plus active cycles", 64'(ac), 64'd4);
        chk("slew plus done pulses", 64'(dc), 64'd1);
        chk("incr back to nominal", 64'(incr_time_ns), 64'd5);

        tick();
        run_slew(1'b0, 32'd8, 7'd0, 3, 6, 64'd0, ac, dc);
        chk("slew minus active cycles", 64'(ac), 64'd3);
        chk("slew minus done pulses", 64'(dc), 64'd1);

        tick();
        nom_incr_ns = 32'hFFFF_FFFF; nom_incr_sub_ns = 7'h70;
        tick();
        run_slew(1'b1, 32'd0, 7'h20, 2, 5, MAXV, ac, dc);
        chk("saturate plus active cycles", 64'(ac), 64'd2);
        tick();
        nom_incr_ns = 32'd5; nom_incr_sub_ns = '0;
        tick();

        run_slew(1'b1, 32'd3, 7'd0, 0, 5, 64'd0, ac, dc);
        chk("zero-length slew active cycles", 64'(ac), 64'd0);
        chk("zero-length slew done pulses", 64'(dc), 64'd1);

        // long slew, step during it, nominal change, then init abort with 10 cycles left
        tick();
        slew_req_valid = 1; slew_req_plus = 1; slew_req_delta_ns = 32'd2; slew_req_delta_sub_ns = '0;
        slew_req_cycles = CW'(20);
        tick();
        slew_req_valid = 0;
        repeat (3) tick();
        step_req_valid = 1; step_req_plus = 0; step_req_ns = 32'd7; step_req_sub_ns = 7'h11;
        tick();
        step_req_valid = 0;
        tick();
        nom_incr_ns = 32'd7;
        tick();
        @(negedge clk);
        chk("nominal change during slew", 64'(incr_time_ns), 64'd9);
        chk("slew still active after step", 64'(slew_active), 64'd1);
        repeat (3) tick();
        init_req_valid = 1; init_req_sec = 32'd42; init_req_ns = 32'd9; init_req_sub_ns = 7'h01;
        tick();
        init_req_valid = 0;
        @(negedge clk);
        chk("incr nominal after abort", 64'(incr_time_ns), 64'd7);
        chk("slew_active dropped on abort", 64'(slew_active), 64'd0);
        dc = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (slew_done) dc++;
        end
        chk("no slew_done after abort", 64'(dc), 64'd0);

        // reset during INIT_PULSE
        tick();
        init_req_valid = 1; init_req_sec = 32'd77;
        tick();
        init_req_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("set_init cleared by async reset", 64'(set_init_time), 64'd0);
        chk("busy cleared by async reset", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_req_ready after release", 64'(init_req_ready), 64'd1);
        repeat (6) tick();
        chk("init_time_sec after reset", 64'(init_time_sec), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tod_ctrl.md
# tod_ctrl

Request sequencer and configuration front-end for `tod_core`. Three requester channels, each with a valid/ready handshake: time set (init), phase step (offset), and frequency slew (temporary increment change). The block arbitrates between them with fixed priority and turns accepted requests into the single-cycle `set_init_time` / `set_offset_time` pulses and the `incr_time_*` value that `tod_core` consumes. It sits directly in front of `tod_core`, and its outputs connect port-for-port to the `tod_core` inputs.

## Interface
- `TIME_WIDTH_SUB_NS`, 7: sub-nanosecond field width.
- `TIME_WIDTH_NS`, 32: nanosecond field width.
- `TIME_WIDTH_SEC`, 32: seconds field width.
- `SLEW_CNT_WIDTH`, 16: width of the slew duration counter.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `nom_incr_sub_ns` / `nom_incr_ns`  in  SUB_NS / NS  nominal per-cycle increment.
- `init_req_valid`, `init_req_ready`  in / out  1  time-set handshake.
- `init_req_sub_ns` / `init_req_ns` / `init_req_sec`  in  SUB_NS / NS / SEC  absolute time to load.
- `step_req_valid`, `step_req_ready`  in / out  1  phase-step handshake.
- `step_req_plus`  in  1  1 = add offset, 0 = subtract.
- `step_req_sub_ns` / `step_req_ns`  in  SUB_NS / NS  offset magnitude.
- `slew_req_valid`, `slew_req_ready`  in / out  1  slew handshake.
- `slew_req_plus`  in  1  1 = faster, 0 = slower.
- `slew_req_delta_sub_ns` / `slew_req_delta_ns`  in  SUB_NS / NS  per-cycle increment delta.
- `slew_req_cycles`  in  SLEW_CNT_WIDTH  slew duration in cycles.
- `set_init_time`, `set_offset_time`, `plus_offset_time`  out  1  to `tod_core`.
- `init_time_sub_ns` / `init_time_ns` / `init_time_sec`  out  to `tod_core`.
- `offset_time_sub_ns` / `offset_time_ns`  out  to `tod_core`.
- `incr_time_sub_ns` / `incr_time_ns`  out  to `tod_core`.
- `slew_active`, `slew_done`, `busy`  out  1  status.

## Operation
- Main FSM states and transitions:
  - IDLE → INIT_PULSE on init accept.
  - IDLE → STEP_PULSE on step accept.
  - INIT_PULSE / STEP_PULSE → GUARD, unconditionally.
  - GUARD → IDLE, unconditionally.
- Ready signals (strict priority init > step > slew):
  - `init_req_ready` = (state == IDLE).
  - `step_req_ready` = (state == IDLE) && !`init_req_valid`.
  - `slew_req_ready` = (state == IDLE) && !`slew_active` && !`init_req_valid` && !`step_req_valid`.
- A request is accepted on a clock edge where its valid and ready are both high; request fields are captured at that edge.
- `init_time_*`, `offset_time_*` and `plus_offset_time` are registered. They update only on an accept of their own channel and otherwise hold.
- Slew engine runs concurrently with the main FSM:
  - The slew-mode increment is nominal ± delta, computed as a concatenated {ns, sub_ns} value of NS+SUB_NS bits.
  - Plus saturates at all-ones; minus saturates at 0.
  - The counter is loaded with `slew_req_cycles` and decrements once per active cycle.
- Step accepts are allowed while a slew is active; the slew continues unaffected.
- An init accept aborts any active slew: counter cleared, `slew_active` dropped, increment returns to nominal, and `slew_done` is NOT pulsed.
- `busy` = (state != IDLE) || `slew_active`.

## Timing
- Reset values: every output register is 0, FSM in IDLE, slew counter 0. This includes `incr_time_*`, which takes the nominal value on the first clock after reset release.
- Init/step latency, with the accept at edge N:
  - The pulse (`set_init_time` or `set_offset_time`) is high for exactly the cycle following edge N.
  - Data outputs are valid from that same cycle.
  - GUARD occupies the next cycle; ready returns after edge N+2.
  - Minimum spacing between accepted init/step requests is 3 cycles.
- `incr_time_*` is registered and recomputed every cycle from the current `nom_incr_*` and the next slew state. A change on `nom_incr_*` is visible 1 cycle later, including during a slew.
- Slew with the accept at edge N and C = `slew_req_cycles` > 0:
  - `slew_active` and the adjusted increment are present for exactly C cycles, after edges N+1 through N+C.
  - After edge N+C+1 the increment is nominal and `slew_done` is high for 1 cycle.
- Slew with C = 0: accepted, `slew_active` never asserts, increment stays nominal, and `slew_done` pulses 1 cycle after edge N+1.
- `rst_n` asserted mid-operation: all state and outputs clear immediately (asynchronous); no pending pulse is emitted after release.

## Test plan
- Reset, then nom = 0x5 ns / 0x00 sub → `incr_time_ns` = 5 one cycle after release; all pulses 0.
- Init and step valid in the same IDLE cycle → init accepted first, `set_init_time` 1 cycle, GUARD, then step accepted; `set_offset_time` pulses exactly 3 cycles after `set_init_time`.
- Slew plus, delta 1 ns, C = 4, nom 5 ns → `incr_time_ns` = 6 for 4 cycles, then 5 with a `slew_done` pulse; `slew_active` high for exactly 4 cycles.
- Slew minus, delta 8 ns, nom 5 ns → increment saturates at 0 for the slew duration.
- Init accepted while a slew is active with 10 cycles remaining → increment nominal the next cycle, `slew_active` = 0, `slew_done` never pulses.
- `rst_n` dropped during INIT_PULSE → `set_init_time` goes to 0 immediately; after release FSM is in IDLE and `init_req_ready` = 1.
